// File: rtl/hilihase_pkg.sv
// Shared types for the HILIHASE change-capture path: signal encoding and the
// event record handed from the capture stage to the DPI bridge.
package hilihase_pkg;

  localparam int ID_W_C = 8;
  localparam int TS_W_C = 32;

  typedef enum logic [1:0] {
    ENC_0 = 2'd0,
    ENC_1 = 2'd1,
    ENC_X = 2'd2,
    ENC_Z = 2'd3
  } sig_enc_t;

  // "time" is a keyword, so the timestamp field is named ts
  typedef struct packed {
    logic [ID_W_C-1:0] id;
    sig_enc_t          val;
    logic [TS_W_C-1:0] ts;
    logic              init;
  } event_t;

endpackage

// File: rtl/hilihase_evt_fifo.sv
// First-word fall-through sync FIFO of event records. Storage is not reset;
// the head is forced to zero while empty so outputs read clean after reset.
module hilihase_evt_fifo
  import hilihase_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  event_t        wr_data,
  input  logic          pop,
  output event_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  event_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = level[AW];
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hilihase_event_capture.sv
// Samples N_SIG encoded signals, latches changes with a timestamp, coalesces
// repeats while pending and serializes them lowest-index-first into a FIFO.
module hilihase_event_capture
  import hilihase_pkg::*;
#(
  parameter int N_SIG   = 8,
  parameter int ID_BASE = 1,
  parameter int ID_W    = ID_W_C,
  parameter int TS_W    = TS_W_C,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SIG-1:0]         sig_en,
  input  logic [2*N_SIG-1:0]       sig_val,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [ID_W-1:0]          ev_id,
  output logic [1:0]               ev_val,
  output logic [TS_W-1:0]          ev_time,
  output logic                     ev_init,
  output logic [15:0]              coalesce_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int SEL_W = (N_SIG > 1) ? $clog2(N_SIG) : 1;

  logic             first;
  logic [TS_W-1:0]  ts;
  logic [N_SIG-1:0] pending;
  logic [N_SIG-1:0] init_flag;
  logic [1:0]       prev  [N_SIG];
  logic [1:0]       lval  [N_SIG];
  logic [TS_W-1:0]  ltime [N_SIG];

  logic [N_SIG-1:0] change;
  logic [N_SIG-1:0] popped;
  logic [5:0]       coal_n;
  logic [SEL_W-1:0] sel;
  logic             any_pend;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  event_t           push_ev;
  event_t           head;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Priority arbiter: lowest pending index wins.
  always_comb begin
    any_pend = 1'b0;
    sel      = '0;
    for (int i = N_SIG - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any_pend = 1'b1;
        sel      = SEL_W'(i);
      end
    end
  end

  assign pop  = ev_valid && ev_ready;
  assign push = any_pend && (!full || pop);

  always_comb begin
    push_ev      = '0;
    push_ev.id   = ID_W_C'(ID_BASE) + ID_W_C'(sel);
    push_ev.val  = sig_enc_t'(lval[sel]);
    push_ev.ts   = TS_W_C'(ltime[sel]);
    push_ev.init = init_flag[sel];
  end

  // A change on a still-pending signal that is not leaving this cycle loses an event.
  always_comb begin
    change = '0;
    popped = '0;
    coal_n = '0;
    for (int i = 0; i < N_SIG; i++) begin
      change[i] = sig_en[i] && (sig_val[2*i +: 2] != prev[i]);
      popped[i] = push && (sel == SEL_W'(i));
      if (!first && change[i] && pending[i] && !popped[i]) coal_n = coal_n + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first        <= 1'b1;
      ts           <= '0;
      pending      <= '0;
      coalesce_cnt <= '0;
    end else begin
      first        <= 1'b0;
      ts           <= ts + TS_W'(1);
      coalesce_cnt <= sat_add(coalesce_cnt, coal_n);
      for (int i = 0; i < N_SIG; i++) begin
        if (first)          pending[i] <= sig_en[i];
        else if (change[i]) pending[i] <= 1'b1;
        else if (popped[i]) pending[i] <= 1'b0;
      end
    end
  end

  // The init edge registers current values with time 0; later edges latch changes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SIG; i++) begin
      prev[i] <= sig_val[2*i +: 2];
      if (first ? sig_en[i] : change[i]) begin
        lval[i]      <= sig_val[2*i +: 2];
        ltime[i]     <= first ? '0 : ts;
        init_flag[i] <= first;
      end
    end
  end

  hilihase_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_ev),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign ev_valid = !empty;
  assign ev_id    = ID_W'(head.id);
  assign ev_val   = head.val;
  assign ev_time  = TS_W'(head.ts);
  assign ev_init  = head.init;

endmodule

// File: tb/tb_hilihase_event_capture.sv
// Directed bench for hilihase_event_capture: init burst, single and paired
// changes, FIFO-full coalescing, X/Z encodings, enable gating and mid-run reset.
module tb_hilihase_event_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sig_en;
  logic [15:0] sig_val;
  logic        ev_valid;
  logic        ev_ready;
  logic [7:0]  ev_id;
  logic [1:0]  ev_val;
  logic [31:0] ev_time;
  logic        ev_init;
  logic [15:0] coalesce_cnt;
  logic [4:0]  fifo_level;

  int checks   = 0;
  int failures = 0;
  int ts_model = 0;
  int t3, t4, t5;

  hilihase_event_capture dut (
    .clk          (clk),
    .rst          (rst),
    .sig_en       (sig_en),
    .sig_val      (sig_val),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_id        (ev_id),
    .ev_val       (ev_val),
    .ev_time      (ev_time),
    .ev_init      (ev_init),
    .coalesce_cnt (coalesce_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // Timestamp the DUT should use at the next rising edge.
  always @(posedge clk) ts_model <= rst ? 0 : ts_model + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_sig(input int i, input logic [1:0] v);
    sig_val[2*i +: 2] = v;
  endtask

  task automatic expect_event(input string tag, input int id, input int val, input int t,
                              input int init, input int max_wait);
    for (int w = 0; w < max_wait && !ev_valid; w++) step(1);
    check_eq({tag, "_valid"}, ev_valid, 1);
    check_eq({tag, "_id"},    ev_id,    id);
    check_eq({tag, "_val"},   ev_val,   val);
    check_eq({tag, "_time"},  ev_time,  t);
    check_eq({tag, "_init"},  ev_init,  init);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sig_en   = 8'hFF;
    sig_val  = '0;
    ev_ready = 1'b0;
    rst      = 1'b1;
    step(3);
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_id",    ev_id,    0);
    check_eq("rst_val",   ev_val,   0);
    check_eq("rst_time",  ev_time,  0);
    check_eq("rst_init",  ev_init,  0);
    check_eq("rst_coal",  coalesce_cnt, 0);
    check_eq("rst_level", fifo_level,   0);

    // Init burst: visible only after the second edge.
    rst = 1'b0;
    step(1);
    check_eq("init_not_yet", ev_valid, 0);
    ev_ready = 1'b1;
    step(1);
    for (int k = 0; k < 8; k++) expect_event($sformatf("init%0d", k), k + 1, 0, 0, 1, 0);
    check_eq("init_drained", ev_valid, 0);

    // Single change on signal 2 sampled at ts=10.
    for (int w = 0; w < 20 && ts_model < 10; w++) step(1);
    set_sig(2, 2'd1);
    step(1);
    check_eq("chg_lat_e0", ev_valid, 0);
    step(1);
    check_eq("chg_valid", ev_valid, 1);
    check_eq("chg_id",    ev_id,    3);
    check_eq("chg_val",   ev_val,   1);
    check_eq("chg_time",  ev_time,  10);
    check_eq("chg_init",  ev_init,  0);
    step(1);
    check_eq("chg_single", ev_valid, 0);

    // Signals 5 and 1 change together: index order, same time.
    t3 = ts_model;
    set_sig(1, 2'd1);
    set_sig(5, 2'd1);
    expect_event("pair_a", 2, 1, t3, 0, 3);
    expect_event("pair_b", 6, 1, t3, 0, 0);
    check_eq("pair_done", ev_valid, 0);

    // Stall the consumer and toggle signal 0 for 40 edges.
    ev_ready = 1'b0;
    t4 = ts_model;
    for (int j = 1; j <= 40; j++) begin
      set_sig(0, (j % 2 == 1) ? 2'd1 : 2'd0);
      step(1);
    end
    check_eq("full_level", fifo_level,   16);
    check_eq("full_coal",  coalesce_cnt, 23);
    check_eq("full_id",    ev_id,        1);
    check_eq("full_time",  ev_time,      t4);
    step(2);
    check_eq("hold_level", fifo_level, 16);
    check_eq("hold_val",   ev_val,     1);
    check_eq("hold_time",  ev_time,    t4);
    ev_ready = 1'b1;
    for (int j = 1; j <= 16; j++)
      expect_event($sformatf("drain%0d", j), 1, j % 2, t4 + j - 1, 0, 0);
    expect_event("coal_last", 1, 0, t4 + 39, 0, 0);
    check_eq("drain_empty", ev_valid, 0);
    check_eq("drain_coal",  coalesce_cnt, 23);

    // Signal 4 through 1, X, Z on consecutive edges.
    t5 = ts_model;
    set_sig(4, 2'd1);
    step(1);
    set_sig(4, 2'd2);
    step(1);
    set_sig(4, 2'd3);
    expect_event("enc1", 5, 1, t5,     0, 3);
    expect_event("encX", 5, 2, t5 + 1, 0, 0);
    expect_event("encZ", 5, 3, t5 + 2, 0, 0);
    check_eq("enc_done", ev_valid, 0);

    // Disabled signal changes and a bare enable toggle produce nothing.
    sig_en[4] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_sig(4, 2'(k));
      step(1);
    end
    step(3);
    check_eq("dis_valid", ev_valid,   0);
    check_eq("dis_level", fifo_level, 0);
    sig_en[4] = 1'b1;
    step(3);
    check_eq("en_quiet", ev_valid, 0);
    check_eq("en_coal",  coalesce_cnt, 23);

    // Queue 5 events, then reset mid-operation.
    ev_ready = 1'b0;
    set_sig(0, 2'd1);
    set_sig(1, 2'd0);
    set_sig(2, 2'd0);
    set_sig(3, 2'd1);
    set_sig(4, 2'd0);
    step(6);
    check_eq("q5_level", fifo_level, 5);
    rst = 1'b1;
    step(1);
    check_eq("mrst_valid", ev_valid,     0);
    check_eq("mrst_level", fifo_level,   0);
    check_eq("mrst_coal",  coalesce_cnt, 0);
    check_eq("mrst_id",    ev_id,        0);
    rst = 1'b0;
    step(1);
    check_eq("reinit_not_yet", ev_valid, 0);
    step(1);
    check_eq("reinit_valid", ev_valid, 1);
    check_eq("reinit_id",    ev_id,    1);
    check_eq("reinit_val",   ev_val,   1);
    check_eq("reinit_time",  ev_time,  0);
    check_eq("reinit_init",  ev_init,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
